// File: rtl/fifo_pkg.sv
// Shared helpers and types for the synchronous FIFO and anything that monitors it.
package fifo_pkg;

    // Address width for a storage array; never returns 0 so a port is always at least 1 bit.
    function automatic int unsigned clog2_safe(input int unsigned n);
        int unsigned r;
        r = $clog2(n);
        return (r < 1) ? 1 : r;
    endfunction

    // Occupancy counter width: one extra bit so DEPTH itself is representable.
    function automatic int unsigned cw_of(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH storage with a synchronous write port and a registered read port.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW = clog2_safe(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // Storage words; deliberately not reset, the pointers guarantee stale words are never read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Read register holds its value when no read is requested; reads see the pre-write word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointer/count bookkeeping, status flags and error pulses around fifo_mem.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned CW = cw_of(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned AW = clog2_safe(DEPTH);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_rd_valid;
    logic          r_overflow;
    logic          r_underflow;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_count_d;

    // Flags decoded from the registered count; the pointers alone are ambiguous when equal.
    always_comb begin
        w_full  = (r_count == CW'(DEPTH));
        w_empty = (r_count == '0);
        w_pop   = rd_en && !w_empty;
        // A full FIFO still accepts a push when a pop frees the slot on the same edge.
        w_push  = wr_en && (!w_full || w_pop);
        w_count_d = r_count;
        if (w_push && !w_pop) begin
            w_count_d = r_count + CW'(1);
        end else if (w_pop && !w_push) begin
            w_count_d = r_count - CW'(1);
        end
    end

    // Pointer, count and one-cycle status pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count     <= w_count_d;
            r_rd_valid  <= w_pop;
            r_overflow  <= wr_en && w_full && !rd_en;
            r_underflow <= rd_en && w_empty;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_push),
        .wr_addr (r_wr_ptr),
        .wr_data (wr_data),
        .rd_en   (w_pop),
        .rd_addr (r_rd_ptr),
        .rd_data (rd_data)
    );

    assign rd_valid  = r_rd_valid;
    assign full      = w_full;
    assign empty     = w_empty;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed, table-driven bench for sync_fifo at WIDTH=8, DEPTH=4.
module tb_sync_fifo;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             wr_en = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             rd_en = 1'b0;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        wr;
        logic [7:0]  wd;
        logic        rd;
        logic [15:0] want;
    } vec_t;

    vec_t vecs[$];

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    // Expected output record: {rd_data, rd_valid, full, empty, count, overflow, underflow}.
    function automatic logic [15:0] exp_out(logic [7:0] d, logic v, logic f, logic e,
                                            logic [2:0] c, logic o, logic u);
        return {d, v, f, e, c, o, u};
    endfunction

    task automatic check(input string name, input logic [15:0] want);
        logic [15:0] got;
        got = {rd_data, rd_valid, full, empty, count, overflow, underflow};
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got data=%h v=%b full=%b empty=%b cnt=%0d ovf=%b unf=%b ; want data=%h v=%b full=%b empty=%b cnt=%0d ovf=%b unf=%b",
                     name, got[15:8], got[7], got[6], got[5], got[4:2], got[1], got[0],
                     want[15:8], want[7], want[6], want[5], want[4:2], want[1], want[0]);
        end
    endtask

    // One clock of stimulus, outputs sampled 1 time unit after the rising edge.
    task automatic step(input logic wr, input logic [7:0] wd, input logic rd,
                        input logic [15:0] want, input string name);
        wr_en   = wr;
        wr_data = wd;
        rd_en   = rd;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        check(name, want);
    endtask

    task automatic add(input logic wr, input logic [7:0] wd, input logic rd,
                       input logic [15:0] want);
        vec_t v;
        v.wr   = wr;
        v.wd   = wd;
        v.rd   = rd;
        v.want = want;
        vecs.push_back(v);
    endtask

    initial begin
        logic [7:0] prev;

        // Fill and drain, overflow, underflow.
        add(1, 8'h11, 0, exp_out(8'h00, 0, 0, 0, 3'd1, 0, 0));
        add(1, 8'h22, 0, exp_out(8'h00, 0, 0, 0, 3'd2, 0, 0));
        add(1, 8'h33, 0, exp_out(8'h00, 0, 0, 0, 3'd3, 0, 0));
        add(1, 8'h44, 0, exp_out(8'h00, 0, 1, 0, 3'd4, 0, 0));
        add(1, 8'hFF, 0, exp_out(8'h00, 0, 1, 0, 3'd4, 1, 0));
        add(0, 8'h00, 0, exp_out(8'h00, 0, 1, 0, 3'd4, 0, 0));
        add(0, 8'h00, 1, exp_out(8'h11, 1, 0, 0, 3'd3, 0, 0));
        add(0, 8'h00, 1, exp_out(8'h22, 1, 0, 0, 3'd2, 0, 0));
        add(0, 8'h00, 1, exp_out(8'h33, 1, 0, 0, 3'd1, 0, 0));
        add(0, 8'h00, 1, exp_out(8'h44, 1, 0, 1, 3'd0, 0, 0));
        add(0, 8'h00, 1, exp_out(8'h44, 0, 0, 1, 3'd0, 0, 1));
        add(0, 8'h00, 0, exp_out(8'h44, 0, 0, 1, 3'd0, 0, 0));
        // Refill, then simultaneous push/pop while full.
        add(1, 8'h11, 0, exp_out(8'h44, 0, 0, 0, 3'd1, 0, 0));
        add(1, 8'h22, 0, exp_out(8'h44, 0, 0, 0, 3'd2, 0, 0));
        add(1, 8'h33, 0, exp_out(8'h44, 0, 0, 0, 3'd3, 0, 0));
        add(1, 8'h44, 0, exp_out(8'h44, 0, 1, 0, 3'd4, 0, 0));
        add(1, 8'h55, 1, exp_out(8'h11, 1, 1, 0, 3'd4, 0, 0));
        add(0, 8'h00, 1, exp_out(8'h22, 1, 0, 0, 3'd3, 0, 0));
        add(0, 8'h00, 1, exp_out(8'h33, 1, 0, 0, 3'd2, 0, 0));
        add(0, 8'h00, 1, exp_out(8'h44, 1, 0, 0, 3'd1, 0, 0));
        add(0, 8'h00, 1, exp_out(8'h55, 1, 0, 1, 3'd0, 0, 0));
        // Simultaneous push/pop while empty: no bypass.
        add(1, 8'h66, 1, exp_out(8'h55, 0, 0, 0, 3'd1, 0, 1));
        add(0, 8'h00, 1, exp_out(8'h66, 1, 0, 1, 3'd0, 0, 0));
        // Wrap-around: ten push/pop pairs.
        prev = 8'h66;
        for (int i = 0; i < 10; i++) begin
            add(1, 8'(i), 0, exp_out(prev, 0, 0, 0, 3'd1, 0, 0));
            add(0, 8'h00, 1, exp_out(8'(i), 1, 0, 1, 3'd0, 0, 0));
            prev = 8'(i);
        end

        // Asynchronous reset with no clock edge in between.
        #1 rst = 1'b1;
        #1 check("reset_async", exp_out(8'h00, 0, 0, 1, 3'd0, 0, 0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].wr, vecs[i].wd, vecs[i].rd, vecs[i].want, $sformatf("vec%0d", i));
        end

        // Reset mid-operation with count=3 and rd_valid high.
        step(1, 8'hA1, 0, exp_out(8'h09, 0, 0, 0, 3'd1, 0, 0), "midop_push1");
        step(1, 8'hA2, 0, exp_out(8'h09, 0, 0, 0, 3'd2, 0, 0), "midop_push2");
        step(1, 8'hA3, 0, exp_out(8'h09, 0, 0, 0, 3'd3, 0, 0), "midop_push3");
        step(1, 8'hA4, 0, exp_out(8'h09, 0, 1, 0, 3'd4, 0, 0), "midop_push4");
        step(0, 8'h00, 1, exp_out(8'hA1, 1, 0, 0, 3'd3, 0, 0), "midop_pop");
        #3 rst = 1'b1;
        #1 check("reset_midop", exp_out(8'h00, 0, 0, 1, 3'd0, 0, 0));
        @(negedge clk);
        rst = 1'b0;
        step(1, 8'hA5, 0, exp_out(8'h00, 0, 0, 0, 3'd1, 0, 0), "post_reset_push");
        step(0, 8'h00, 1, exp_out(8'hA5, 1, 0, 1, 3'd0, 0, 0), "post_reset_pop");
        step(0, 8'h00, 1, exp_out(8'hA5, 0, 0, 1, 3'd0, 0, 1), "post_reset_stale");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
